// File: rtl/pid_incr.sv
// -----------------------------------------------------------------------------
// pid_incr -- incremental (velocity-form) PID controller step.
//
// Accepts one error triple e(k), e(k-1), e(k-2) plus Q4.4 gains, runs it
// through a single shared signed multiplier over three cycles, then updates
// the held control value u by du = (kp*dp + ki*di + kd*dd) >>> 4, clamped to
// [0, UMAX].
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of controller state (aborts a transaction)
//   err_valid  error triple valid
//   err_ready  block can accept a triple (IDLE only)
//   ek0..ek2   signed e(k), e(k-1), e(k-2)
//   kp, ki, kd unsigned Q4.4 gains
//   u          registered unsigned control value
//   u_valid    one-cycle pulse, u just updated
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module pid_incr #(
    parameter int EW   = 10,
    parameter int KW   = 8,
    parameter int UW   = 10,
    parameter int UMAX = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 err_valid,
    output logic                 err_ready,
    input  logic signed [EW-1:0] ek0,
    input  logic signed [EW-1:0] ek1,
    input  logic signed [EW-1:0] ek2,
    input  logic        [KW-1:0] kp,
    input  logic        [KW-1:0] ki,
    input  logic        [KW-1:0] kd,
    output logic        [UW-1:0] u,
    output logic                 u_valid,
    output logic                 busy
);

    // Data operand wide enough for dd = ek0 - 2*ek1 + ek2 without overflow.
    localparam int DW = EW + 2;
    localparam int GW = KW + 1;          // gain zero-extended to signed
    localparam int PW = DW + GW;         // full product width
    localparam int AW = EW + KW + 5;     // accumulator width
    localparam int NW = AW + 2;          // u + du, never overflows

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_I = 3'd2,
        MUL_D = 3'd3,
        ACC   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic signed [EW-1:0]  ek0_r, ek1_r, ek2_r;
    logic        [KW-1:0]  kp_r, ki_r, kd_r;
    logic signed [AW-1:0]  acc_r;
    logic        [UW-1:0]  u_r;
    logic                  u_valid_r;
    logic                  busy_r;
    logic                  err_ready_r;

    logic                  transfer_s;
    logic signed [DW-1:0]  ek0_x_s, ek1_x_s, ek2_x_s;
    logic signed [DW-1:0]  dp_s, di_s, dd_s;
    logic signed [DW-1:0]  mul_a_s;
    logic signed [GW-1:0]  mul_g_s;
    logic signed [PW-1:0]  mul_a_x_s, mul_g_x_s, prod_s;
    logic signed [AW-1:0]  prod_ext_s;
    logic signed [AW-1:0]  du_s;
    logic signed [NW-1:0]  u_next_s;

    // Saturate the signed candidate value into the unsigned output range.
    function automatic logic [UW-1:0] clamp_u(input logic signed [NW-1:0] v);
        logic [UW-1:0] r;
        if (v[NW-1]) begin
            r = {UW{1'b0}};
        end else if (v > NW'(UMAX)) begin
            r = UW'(UMAX);
        end else begin
            r = v[UW-1:0];
        end
        return r;
    endfunction

    // err_ready_r is only ever set on entry to IDLE, so it also gates transfer
    // during the first cycle after reset release.
    assign transfer_s = (state_r == IDLE) && err_valid && err_ready_r;

    assign ek0_x_s = {{(DW-EW){ek0_r[EW-1]}}, ek0_r};
    assign ek1_x_s = {{(DW-EW){ek1_r[EW-1]}}, ek1_r};
    assign ek2_x_s = {{(DW-EW){ek2_r[EW-1]}}, ek2_r};
    assign dp_s    = ek0_x_s - ek1_x_s;
    assign di_s    = ek0_x_s;
    assign dd_s    = ek0_x_s - (ek1_x_s <<< 1) + ek2_x_s;

    // Shared multiplier operand select, one term per MUL_* state.
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_g_s = {GW{1'b0}};
        case (state_r)
            MUL_P: begin
                mul_a_s = dp_s;
                mul_g_s = $signed({1'b0, kp_r});
            end
            MUL_I: begin
                mul_a_s = di_s;
                mul_g_s = $signed({1'b0, ki_r});
            end
            MUL_D: begin
                mul_a_s = dd_s;
                mul_g_s = $signed({1'b0, kd_r});
            end
            default: begin
                mul_a_s = {DW{1'b0}};
                mul_g_s = {GW{1'b0}};
            end
        endcase
    end

    // Operands are sign-extended to full product width so the multiply is exact.
    assign mul_a_x_s  = {{(PW-DW){mul_a_s[DW-1]}}, mul_a_s};
    assign mul_g_x_s  = {{(PW-GW){mul_g_s[GW-1]}}, mul_g_s};
    assign prod_s     = mul_a_x_s * mul_g_x_s;
    assign prod_ext_s = {{(AW-PW){prod_s[PW-1]}}, prod_s};

    // Q4.4 gain scaling: arithmetic shift floors toward -inf.
    assign du_s     = acc_r >>> 4;
    assign u_next_s = $signed({{(NW-UW){1'b0}}, u_r}) + {{(NW-AW){du_s[AW-1]}}, du_s};

    // Next-state logic: fixed sequence once a triple is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    state_next_s = MUL_P;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL_P:   state_next_s = MUL_I;
            MUL_I:   state_next_s = MUL_D;
            MUL_D:   state_next_s = ACC;
            ACC:     state_next_s = OUT;
            OUT:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            err_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            u_valid_r   <= 1'b0;
        end else if (clr) begin
            state_r     <= IDLE;
            err_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            u_valid_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            err_ready_r <= (state_next_s == IDLE);
            busy_r      <= (state_next_s != IDLE);
            u_valid_r   <= (state_next_s == OUT);
        end
    end

    // Capture the triple and gains on transfer; held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ek0_r <= {EW{1'b0}};
            ek1_r <= {EW{1'b0}};
            ek2_r <= {EW{1'b0}};
            kp_r  <= {KW{1'b0}};
            ki_r  <= {KW{1'b0}};
            kd_r  <= {KW{1'b0}};
        end else if (clr) begin
            ek0_r <= {EW{1'b0}};
            ek1_r <= {EW{1'b0}};
            ek2_r <= {EW{1'b0}};
            kp_r  <= {KW{1'b0}};
            ki_r  <= {KW{1'b0}};
            kd_r  <= {KW{1'b0}};
        end else if (transfer_s) begin
            ek0_r <= ek0;
            ek1_r <= ek1;
            ek2_r <= ek2;
            kp_r  <= kp;
            ki_r  <= ki;
            kd_r  <= kd;
        end else begin
            ek0_r <= ek0_r;
            ek1_r <= ek1_r;
            ek2_r <= ek2_r;
            kp_r  <= kp_r;
            ki_r  <= ki_r;
            kd_r  <= kd_r;
        end
    end

    // Accumulator: MUL_P starts a fresh sum, MUL_I/MUL_D add to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {AW{1'b0}};
        end else if (clr) begin
            acc_r <= {AW{1'b0}};
        end else begin
            case (state_r)
                MUL_P:        acc_r <= prod_ext_s;
                MUL_I, MUL_D: acc_r <= acc_r + prod_ext_s;
                default:      acc_r <= acc_r;
            endcase
        end
    end

    // Control value: only updated on the ACC->OUT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_r <= {UW{1'b0}};
        end else if (clr) begin
            u_r <= {UW{1'b0}};
        end else if (state_r == ACC) begin
            u_r <= clamp_u(u_next_s);
        end else begin
            u_r <= u_r;
        end
    end

    assign err_ready = err_ready_r;
    assign busy      = busy_r;
    assign u_valid   = u_valid_r;
    assign u         = u_r;

endmodule

// File: tb/tb_pid_incr.sv
// -----------------------------------------------------------------------------
// tb_pid_incr -- self-checking bench for pid_incr: directed vector table,
// hand-written handshake/abort sequences and randomized transactions checked
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pid_incr;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              err_valid;
    logic              err_ready;
    logic signed [9:0] ek0, ek1, ek2;
    logic        [7:0] kp, ki, kd;
    logic        [9:0] u;
    logic              u_valid;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int model_u = 0;

    typedef struct {
        int ek0;
        int ek1;
        int ek2;
        int kp;
        int ki;
        int kd;
        int exp_u;
    } vec_t;

    vec_t tbl[14];
    int   exp_q[$];

    pid_incr #(.EW(10), .KW(8), .UW(10), .UMAX(1023)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .err_valid(err_valid),
        .err_ready(err_ready),
        .ek0      (ek0),
        .ek1      (ek1),
        .ek2      (ek2),
        .kp       (kp),
        .ki       (ki),
        .kd       (kd),
        .u        (u),
        .u_valid  (u_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: velocity-form PID step with floor division and saturation.
    function automatic int ref_step(input int uc, input vec_t v);
        int sum, du, un;
        sum = v.kp * (v.ek0 - v.ek1) + v.ki * v.ek0 + v.kd * (v.ek0 - 2 * v.ek1 + v.ek2);
        if (sum >= 0) du = sum / 16;
        else          du = -((15 - sum) / 16);
        un = uc + du;
        if (un < 0)    un = 0;
        if (un > 1023) un = 1023;
        return un;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ek0 = 10'(v.ek0);
        ek1 = 10'(v.ek1);
        ek2 = 10'(v.ek2);
        kp  = 8'(v.kp);
        ki  = 8'(v.ki);
        kd  = 8'(v.kd);
    endtask

    task automatic drive_garbage();
        ek0 = 10'($urandom);
        ek1 = 10'($urandom);
        ek2 = 10'($urandom);
        kp  = 8'($urandom);
        ki  = 8'($urandom);
        kd  = 8'($urandom);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.ek0 = int'($urandom_range(0, 1023)) - 512;
        v.ek1 = int'($urandom_range(0, 1023)) - 512;
        v.ek2 = int'($urandom_range(0, 1023)) - 512;
        v.kp  = int'($urandom_range(0, 63));
        v.ki  = int'($urandom_range(0, 63));
        v.kd  = int'($urandom_range(0, 63));
        v.exp_u = 0;
        return v;
    endfunction

    // Leaves the bench at a falling edge with err_ready high (or reports a timeout).
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!err_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(err_ready), 1);
    endtask

    task automatic run_txn(input vec_t v, input int exp_u, input string nm);
        int lat;
        bit got;
        wait_ready();
        drive(v);
        err_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_valid = 1'b0;
        drive_garbage();
        lat = 1;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (u_valid) got = 1'b1;
        end
        chk({nm, "_lat"}, got ? lat : -1, 5);
        chk({nm, "_u"}, int'(u), exp_u);
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, int'(u_valid), 0);
        chk({nm, "_hold"}, int'(u), exp_u);
    endtask

    task automatic watch_no_valid(input string nm);
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (u_valid) pulses++;
        end
        chk({nm, "_no_valid"}, pulses, 0);
        chk({nm, "_u_zero"}, int'(u), 0);
    endtask

    initial begin
        vec_t v;
        rst_n     = 1'b0;
        clr       = 1'b0;
        err_valid = 1'b0;
        ek0 = '0; ek1 = '0; ek2 = '0;
        kp  = '0; ki  = '0; kd  = '0;

        tbl = '{
            '{  10, 0, 0, 16,  0,  0,   10},
            '{ 511, 0, 0, 16,  0,  0,  521},
            '{ 499, 0, 0, 16,  0,  0, 1020},
            '{ 100, 0, 0,  0, 16,  0, 1023},
            '{ 100, 0, 0,  0, 16,  0, 1023},
            '{-512, 0, 0,  0, 16,  0,  511},
            '{-512, 0, 0,  0, 16,  0,    0},
            '{   5, 0, 0, 16,  0,  0,    5},
            '{  -1, 0, 0,  8,  0,  0,    4},
            '{  -1, 0, 0, 16,  0,  0,    3},
            '{-512, 0, 0, 16,  0,  0,    0},
            '{ 100, 0, 0, 16,  0,  0,  100},
            '{   4, 2, 0,  0,  0, 16,  100},
            '{   4, 2, 3,  0,  0, 16,  103}
        };

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_u", int'(u), 0);
        chk("rst_u_valid", int'(u_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_ready", int'(err_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_err_ready_early", int'(err_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_err_ready", int'(err_ready), 1);

        // Directed vector table (u carries over between rows)
        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i], tbl[i].exp_u, $sformatf("tbl%0d", i));
            model_u = tbl[i].exp_u;
        end

        // err_valid held high: one transfer per 6 cycles, garbage between transfers
        wait_ready();
        for (int c = 1; c <= 24; c++) begin
            if (c % 6 == 1) begin
                v = rand_vec();
                model_u = ref_step(model_u, v);
                exp_q.push_back(model_u);
                drive(v);
            end else begin
                drive_garbage();
            end
            err_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("b2b_busy%0d", c), int'(busy), int'(c % 6 != 0));
            chk($sformatf("b2b_ready%0d", c), int'(err_ready), int'(c % 6 == 0));
            chk($sformatf("b2b_valid%0d", c), int'(u_valid), int'(c % 6 == 5));
            if (c % 6 == 5) chk($sformatf("b2b_u%0d", c), int'(u), exp_q.pop_front());
            @(negedge clk);
        end
        err_valid = 1'b0;

        // clr abort while in MUL_I
        v = '{200, 0, 0, 16, 0, 0, 0};
        model_u = ref_step(model_u, v);
        run_txn(v, model_u, "pre_clr");
        wait_ready();
        drive(v);
        err_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_u", int'(u), 0);
        chk("clr_u_valid", int'(u_valid), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_err_ready", int'(err_ready), 1);
        @(negedge clk);
        clr = 1'b0;
        watch_no_valid("clr");
        model_u = 0;

        // clr wins over a simultaneous transfer
        wait_ready();
        drive(v);
        err_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_vs_xfer_busy", int'(busy), 0);
        @(negedge clk);
        clr = 1'b0;
        err_valid = 1'b0;
        watch_no_valid("clr_vs_xfer");

        // rst_n abort while in MUL_I
        model_u = ref_step(model_u, v);
        run_txn(v, model_u, "pre_rst");
        wait_ready();
        drive(v);
        err_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_u", int'(u), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_err_ready", int'(err_ready), 0);
        chk("arst_u_valid", int'(u_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rel_ready", int'(err_ready), 1);
        watch_no_valid("arst");
        model_u = 0;

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            v = rand_vec();
            model_u = ref_step(model_u, v);
            run_txn(v, model_u, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pid_incr.md
PID_INCR -- requirements
Module: pid_incr

Interface
REQ-001 SHALL have parameters: EW, 10, error width; KW, 8, unsigned gain width (Q4.4); UW, 10, control output width; UMAX, 1023, output upper clamp.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear of controller state.
REQ-005 SHALL have port err_valid  input  1  error triple valid.
REQ-006 SHALL have port err_ready  output  1  block can accept a triple.
REQ-007 SHALL have ports ek0, ek1, ek2  input  EW each  signed e(k), e(k-1), e(k-2).
REQ-008 SHALL have ports kp, ki, kd  input  KW each  unsigned gains, Q4.4.
REQ-009 SHALL have port u  output  UW  unsigned control value (PWM duty), registered.
REQ-010 SHALL have port u_valid  output  1  one-cycle pulse, u just updated.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL use FSM states IDLE, MUL_P, MUL_I, MUL_D, ACC, OUT, advancing one state per clock in that order, OUT returning to IDLE.
REQ-013 SHALL drive err_ready = 1 only in IDLE; transfer occurs on an edge with err_valid && err_ready.
REQ-014 SHALL, on transfer, capture ek0..ek2 and kp/ki/kd into internal registers; later input changes do not affect the transaction.
REQ-015 SHALL compute dp = ek0-ek1 (EW+1 signed), di = ek0, dd = ek0-2*ek1+ek2 (EW+2 signed), no overflow at any input value.
REQ-016 SHALL use one shared signed multiplier: MUL_P forms kp*dp, MUL_I ki*di, MUL_D kd*dd; gains zero-extended to signed; products summed in an accumulator of at least EW+KW+5 bits.
REQ-017 SHALL, in ACC, form du = sum >>> 4 (arithmetic shift, floor toward -inf), then u_next = u + du at full width.
REQ-018 SHALL clamp u_next: < 0 -> 0; > UMAX -> UMAX; else u_next; result registered into u at the ACC->OUT edge.
REQ-019 SHALL assert u_valid exactly during the OUT state (one cycle); u_valid first high on the 5th rising edge after the transfer edge, counting the transfer edge as the 1st.
REQ-020 SHALL ignore err_valid while busy; no queuing, no loss of the in-flight transaction.
REQ-021 SHALL accept a new transfer in the cycle after OUT (back-to-back throughput: one result per 6 cycles).
REQ-022 SHALL, on clr high at a rising edge, set u=0, u_valid=0, FSM=IDLE, discarding any in-flight transaction; clr overrides a simultaneous transfer.
REQ-023 SHALL keep u unchanged between updates; u changes only at ACC->OUT or on clr/reset.

Reset
REQ-024 SHALL, while rst_n low, force FSM=IDLE, u=0, u_valid=0, busy=0, err_ready=0 and clear all internal registers.
REQ-025 SHALL drive err_ready=1 from the first clock after rst_n deasserts; reset mid-transaction aborts it with no u_valid.

Verification
REQ-026 SHALL check proportional step: u=0, kp=16, ki=kd=0, ek0=10, ek1=ek2=0 -> u_valid pulse 5th edge, u=10.
REQ-027 SHALL check high clamp: u=1020, ki=16, kp=kd=0, ek0=100 -> u=1023; repeat -> u stays 1023 with u_valid pulse.
REQ-028 SHALL check low clamp and floor: u=5, kp=8, ek0=-1, ek1=0 -> du=-1, u=4; then u=3, kp=16, ek0=-512 -> u=0.
REQ-029 SHALL check derivative: kd=16, kp=ki=0, ek0=4, ek1=2, ek2=0, u=100 -> dd=0, u=100; ek2=3 -> dd=3, u=103.
REQ-030 SHALL check busy handling: err_valid held high continuously -> exactly one transfer per 6 cycles, input changes mid-transaction have no effect.
REQ-031 SHALL check abort: clr or rst_n asserted in MUL_I -> no u_valid, u=0, err_ready high next cycle (clr) / after deassert (rst_n).
